res_capture: RTL and testbench

Downstream capture stage for the 30-bit result word of the stimulus-mapping DUT. Each accepted result word is checked against its fixed constant fields, and any mismatch is counted. The 10 data-dependent bits are unpacked back into stimulus order and buffered in a small FIFO, which drains into the results writer over a valid/ready handshake.

---
 rtl/res_capture_pkg.sv | 19 +
 rtl/res_fifo.sv | 63 ++++++
 rtl/res_capture.sv | 82 ++++++++
 tb/tb_res_capture.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/res_capture_pkg.sv
// Shared constants and the result-word unpacking function for the res_capture stage.
package res_capture_pkg;

    localparam int unsigned RES_W  = 30;
    localparam int unsigned LIVE_W = 10;

    localparam logic [RES_W-1:0] CONST_MASK = 30'h0798CFFF;
    localparam logic [RES_W-1:0] CONST_VAL  = 30'h031086E8;

    // Bit 22 is carried inverted in the result word; undo it to restore stimulus polarity.
    function automatic logic [LIVE_W-1:0] extract_live(input logic [RES_W-1:0] d);
        return {d[29:27], ~d[22], d[21], d[18:16], d[13:12]};
    endfunction

    function automatic logic const_bad(input logic [RES_W-1:0] d);
        return (d & CONST_MASK) != CONST_VAL;
    endfunction

endpackage

// File: rtl/res_fifo.sv
// DEPTH x WIDTH synchronous FIFO; storage is not reset, only pointers and occupancy.
module res_fifo
    import res_capture_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = LIVE_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push, do_pop;

    assign full    = (count_q == CNT_W'(DEPTH));
    assign empty   = (count_q == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= push_data;
    end

    assign pop_data = empty ? '0 : mem_q[rd_ptr_q];

endmodule

// File: rtl/res_capture.sv
// Result-word capture: constant-field checker, counters and FIFO handshake glue.
// Optional: define RES_CAPTURE_DROP_BAD_EN to keep bad words out of the FIFO.
module res_capture
    import res_capture_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [RES_W-1:0]  in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [LIVE_W-1:0] out_data,
    output logic [7:0]        err_cnt,
    output logic              err_flag,
    output logic [15:0]       word_cnt
);

    logic        full, empty;
    logic        accept, bad, push, pop;
    logic [7:0]  err_cnt_q, err_cnt_d;
    logic        err_flag_q, err_flag_d;
    logic [15:0] word_cnt_q, word_cnt_d;

    assign in_ready  = rst_n && !full;
    assign out_valid = !empty;
    assign accept    = in_valid && in_ready;
    assign pop       = out_valid && out_ready;
    assign bad       = const_bad(in_data);

`ifdef RES_CAPTURE_DROP_BAD_EN
    assign push = accept && !bad;
`else
    assign push = accept;
`endif

    res_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (LIVE_W)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data (extract_live(in_data)),
        .pop       (pop),
        .pop_data  (out_data),
        .full      (full),
        .empty     (empty)
    );

    always_comb begin
        err_cnt_d  = err_cnt_q;
        err_flag_d = err_flag_q;
        word_cnt_d = word_cnt_q;
        if (accept) begin
            word_cnt_d = word_cnt_q + 16'd1;
            if (bad) begin
                err_flag_d = 1'b1;
                if (err_cnt_q != '1) err_cnt_d = err_cnt_q + 8'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err_cnt_q  <= '0;
            err_flag_q <= 1'b0;
            word_cnt_q <= '0;
        end else begin
            err_cnt_q  <= err_cnt_d;
            err_flag_q <= err_flag_d;
            word_cnt_q <= word_cnt_d;
        end
    end

    assign err_cnt  = err_cnt_q;
    assign err_flag = err_flag_q;
    assign word_cnt = word_cnt_q;

endmodule

// File: tb/tb_res_capture.sv
// Directed bench for res_capture with a queue scoreboard of expected FIFO output words.
module tb_res_capture;

    localparam int unsigned DEPTH = 4;
    localparam logic [29:0] MASK = 30'h0798CFFF;
    localparam logic [29:0] VAL  = 30'h031086E8;
    localparam int SRC [10] = '{12, 13, 16, 17, 18, 21, 22, 27, 28, 29};
    localparam int FLIP [9] = '{0, 7, 11, 14, 15, 19, 20, 23, 26};

    logic        clk = 1'b0;
    logic        rst_n, in_valid, in_ready, out_valid, out_ready, err_flag;
    logic [29:0] in_data;
    logic [9:0]  out_data;
    logic [7:0]  err_cnt;
    logic [15:0] word_cnt;

    always #5 clk = ~clk;

    res_capture #(.DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .err_cnt   (err_cnt),
        .err_flag  (err_flag),
        .word_cnt  (word_cnt)
    );

    int         errors = 0;
    int         checks = 0;
    logic [9:0] exp_q [$];
    int         m_err = 0;
    bit         m_flag = 1'b0;
    int         m_words = 0;
    bit         m_acc = 1'b0;

    function automatic logic [9:0] ref_live(input logic [29:0] d);
        logic [9:0] r;
        for (int i = 0; i < 10; i++) r[i] = (SRC[i] == 22) ? ~d[SRC[i]] : d[SRC[i]];
        return r;
    endfunction

    function automatic logic [29:0] good_word();
        logic [29:0] r;
        r = 30'($urandom);
        return (r & ~MASK) | VAL;
    endfunction

    function automatic logic [29:0] bad_word(input int k);
        logic [29:0] one;
        one = 30'h1;
        return good_word() ^ (one << FLIP[k % 9]);
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
        end
    endtask

    // One clock: drive, compare against the model, advance the model on the edge.
    task automatic cycle(input logic v, input logic [29:0] d, input logic ordy);
        bit acc, pop, bad;
        in_valid  = v;
        in_data   = d;
        out_ready = ordy;
        #1;
        check("in_ready", 32'(in_ready), 32'(rst_n && (exp_q.size() < DEPTH)));
        check("out_valid", 32'(out_valid), 32'(exp_q.size() > 0));
        check("out_data", 32'(out_data), (exp_q.size() > 0) ? 32'(exp_q[0]) : 32'h0);
        check("err_cnt", 32'(err_cnt), 32'(m_err));
        check("err_flag", 32'(err_flag), 32'(m_flag));
        check("word_cnt", 32'(word_cnt), 32'(m_words & 16'hFFFF));
        acc = v && rst_n && (exp_q.size() < DEPTH);
        pop = rst_n && (exp_q.size() > 0) && ordy;
        bad = (d & MASK) != VAL;
        @(posedge clk);
        if (!rst_n) begin
            exp_q.delete();
            m_err   = 0;
            m_flag  = 1'b0;
            m_words = 0;
        end else begin
            if (pop) void'(exp_q.pop_front());
            if (acc) begin
                m_words++;
                if (bad) begin
                    m_flag = 1'b1;
                    if (m_err < 255) m_err++;
                end
`ifdef RES_CAPTURE_DROP_BAD_EN
                if (!bad) exp_q.push_back(ref_live(d));
`else
                exp_q.push_back(ref_live(d));
`endif
            end
        end
        m_acc = acc;
        #1;
    endtask

    task automatic send(input logic [29:0] d, input logic ordy);
        int n;
        n = 0;
        do begin
            cycle(1'b1, d, ordy);
            n++;
        end while (!m_acc && n < 50);
        if (!m_acc) begin
            errors++;
            $error("FAIL send_timeout: observed=no_accept expected=accept");
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        cycle(1'b0, 30'h0, 1'b0);
        rst_n = 1'b1;

        // Directed words from the plan
        cycle(1'b1, 30'h3B37B6E8, 1'b1);
        check("tp1_data", 32'(out_data), 32'h3FF);
        check("tp1_valid", 32'(out_valid), 32'h1);
        check("tp1_words", 32'(word_cnt), 32'd1);
        cycle(1'b1, 30'h035086E8, 1'b1);
        check("tp2_data", 32'(out_data), 32'h000);
        check("tp2_flag", 32'(err_flag), 32'h0);
        cycle(1'b1, 30'h0, 1'b1);
        check("tp3_errcnt", 32'(err_cnt), 32'd1);
        check("tp3_flag", 32'(err_flag), 32'h1);
`ifdef RES_CAPTURE_DROP_BAD_EN
        check("tp3_valid", 32'(out_valid), 32'h0);
`else
        check("tp3_data", 32'(out_data), 32'h040);
`endif
        cycle(1'b0, 30'h0, 1'b1);

        // Fill to full with the consumer stalled, then drain in order
        for (int i = 0; i < 4; i++) send(good_word(), 1'b0);
        check("full_ready", 32'(in_ready), 32'h0);
        cycle(1'b1, 30'h3B37B6E8, 1'b0);
        send(30'h3B37B6E8, 1'b1);
        repeat (6) cycle(1'b0, 30'h0, 1'b1);
        check("drained_valid", 32'(out_valid), 32'h0);

        // Streaming with mixed good/bad words, then push+pop at full
        for (int i = 0; i < 20; i++) cycle(1'b1, (i % 5 == 3) ? bad_word(i) : good_word(), 1'b1);
        cycle(1'b0, 30'h0, 1'b1);
        for (int i = 0; i < 4; i++) cycle(1'b1, good_word(), 1'b0);
        cycle(1'b1, good_word(), 1'b1);
        cycle(1'b1, good_word(), 1'b1);
        cycle(1'b1, good_word(), 1'b1);
        repeat (5) cycle(1'b0, 30'h0, 1'b1);

        // Saturation after a fresh reset
        rst_n = 1'b0;
        cycle(1'b0, 30'h0, 1'b1);
        rst_n = 1'b1;
        for (int i = 0; i < 300; i++) cycle(1'b1, bad_word(i), 1'b1);
        cycle(1'b0, 30'h0, 1'b1);
        check("sat_errcnt", 32'(err_cnt), 32'hFF);
        check("sat_words", 32'(word_cnt), 32'd300);

        // Reset mid-stream discards buffered words and counters
        cycle(1'b1, good_word(), 1'b0);
        cycle(1'b1, bad_word(2), 1'b0);
        rst_n = 1'b0;
        cycle(1'b1, good_word(), 1'b0);
        check("rst_valid", 32'(out_valid), 32'h0);
        check("rst_data", 32'(out_data), 32'h0);
        check("rst_errcnt", 32'(err_cnt), 32'h0);
        check("rst_flag", 32'(err_flag), 32'h0);
        check("rst_words", 32'(word_cnt), 32'h0);
        rst_n = 1'b1;
        cycle(1'b1, 30'h3B37B6E8, 1'b0);
        check("post_rst_words", 32'(word_cnt), 32'd1);
        check("post_rst_data", 32'(out_data), 32'h3FF);
        repeat (2) cycle(1'b0, 30'h0, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
